// File: rtl/leg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : leg_pkg
// Description : Shared constants, opcode classes and FSM state type for the
//               LEG program-counter sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package leg_pkg;

    // Opcode classes, compared against opcode[5:0]; bits [7:6] are the
    // immediate-mode bits and never take part in decode.
    localparam logic [5:0] COND_FIRST = 6'h20;
    localparam logic [5:0] COND_LAST  = 6'h25;
    localparam logic [5:0] CALL_OP    = 6'h30;
    localparam logic [5:0] RET_OP     = 6'h31;
    localparam logic [5:0] HALT_OP    = 6'h3F;

    // Sequential fetch advance; pc arithmetic wraps modulo 256.
    localparam logic [7:0] PC_STEP    = 8'd4;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    // True when the low six opcode bits fall in the conditional-branch range.
    function automatic logic is_cond_op(input logic [5:0] op);
        return (op >= COND_FIRST) && (op <= COND_LAST);
    endfunction

endpackage
`default_nettype wire

// File: rtl/leg_ret_stack.sv
`default_nettype none
// ============================================================================
// Module      : leg_ret_stack
// Description : Small LIFO return-address stack with full/empty status.
//               Pushes while full and pops while empty are ignored; the
//               caller is responsible for flagging those cases.
// Revision    : 1.0 - initial release
// ============================================================================
module leg_ret_stack #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] top_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [CW-1:0]    cnt_q;
    logic [AW-1:0]    w_wr_idx;
    logic [AW-1:0]    w_rd_idx;

    assign full_o   = (cnt_q == CW'(DEPTH));
    assign empty_o  = (cnt_q == '0);
    assign w_wr_idx = AW'(cnt_q);
    assign w_rd_idx = AW'(cnt_q - CW'(1));
    assign top_o    = mem_q[w_rd_idx];

    // Entry storage and occupancy count; push has priority, never both at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_i && !full_o) begin
            mem_q[w_wr_idx] <= data_i;
            cnt_q           <= cnt_q + CW'(1);
        end else if (pop_i && !empty_o) begin
            cnt_q <= cnt_q - CW'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/leg_pc_seq.sv
`default_nettype none
// ============================================================================
// Module      : leg_pc_seq
// Description : Program-counter sequencer: BOOT/RUN/HALT control, sequential
//               fetch, conditional branches and an optional 4-entry return
//               stack for CALL/RET.
//               Build option: define LEG_PC_CALL_STACK_EN to enable CALL/RET;
//               otherwise those opcodes step sequentially and stack_err is 0.
// Revision    : 1.0 - initial release
// ============================================================================
module leg_pc_seq
    import leg_pkg::*;
#(
    parameter int unsigned UUID = 0,
    parameter string       NAME = ""
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       instr_valid,
    output logic       instr_ready,
    input  logic [7:0] opcode,
    input  logic [7:0] target,
    input  logic       cond_taken,
    input  logic       stall,
    output logic [7:0] pc,
    output logic       branch_taken,
    output logic       halted,
    output logic       stack_err
);
    state_e     state_q;
    logic [7:0] pc_q;
    logic       branch_q;
    logic       halted_q;

    logic       w_accept;
    logic [5:0] w_op;
    logic [7:0] w_pc_inc;
    logic       w_is_cond;
    logic       w_is_halt;

    assign instr_ready = (state_q == ST_RUN) && !stall;
    assign w_accept    = instr_valid && instr_ready;
    assign w_op        = opcode[5:0];
    assign w_pc_inc    = pc_q + PC_STEP;
    assign w_is_cond   = is_cond_op(w_op);
    assign w_is_halt   = (w_op == HALT_OP);

    assign pc           = pc_q;
    assign branch_taken = branch_q;
    assign halted       = halted_q;

`ifdef LEG_PC_CALL_STACK_EN
    logic       stack_err_q;
    logic       w_push;
    logic       w_pop;
    logic       w_full;
    logic       w_empty;
    logic [7:0] w_top;

    // Stack is only touched by accepted CALL/RET that it can service.
    assign w_push = w_accept && (w_op == CALL_OP) && !w_full;
    assign w_pop  = w_accept && (w_op == RET_OP)  && !w_empty;

    leg_ret_stack #(
        .DEPTH (4),
        .WIDTH (8)
    ) u_ret_stack (
        .clk     (clk),
        .rst     (rst),
        .push_i  (w_push),
        .pop_i   (w_pop),
        .data_i  (w_pc_inc),
        .top_o   (w_top),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

    assign stack_err = stack_err_q;
`else
    assign stack_err = 1'b0;
`endif

    // Control FSM with registered pc, branch pulse, halt and error flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_BOOT;
            pc_q     <= 8'h00;
            branch_q <= 1'b0;
            halted_q <= 1'b0;
`ifdef LEG_PC_CALL_STACK_EN
            stack_err_q <= 1'b0;
`endif
        end else begin
            branch_q <= 1'b0;
            case (state_q)
                ST_BOOT: state_q <= ST_RUN;
                ST_RUN: begin
                    if (w_accept) begin
                        if (w_is_halt) begin
                            state_q  <= ST_HALT;
                            halted_q <= 1'b1;
                        end else if (w_is_cond && cond_taken) begin
                            pc_q     <= target;
                            branch_q <= 1'b1;
                        end
`ifdef LEG_PC_CALL_STACK_EN
                        else if (w_op == CALL_OP) begin
                            // Jump is taken even when the return address is dropped.
                            pc_q     <= target;
                            branch_q <= 1'b1;
                            if (w_full) begin
                                stack_err_q <= 1'b1;
                            end
                        end else if (w_op == RET_OP) begin
                            if (w_empty) begin
                                pc_q        <= w_pc_inc;
                                stack_err_q <= 1'b1;
                            end else begin
                                pc_q     <= w_top;
                                branch_q <= 1'b1;
                            end
                        end
`endif
                        else begin
                            pc_q <= w_pc_inc;
                        end
                    end
                end
                ST_HALT: state_q <= ST_HALT;
                default: state_q <= ST_BOOT;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_leg_pc_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_leg_pc_seq
// Description : Directed self-checking bench for leg_pc_seq. A behavioural
//               model tracks pc/flags/stack; every falling edge compares the
//               DUT to it, and literal checks pin the model at key points.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_leg_pc_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       instr_valid = 1'b0;
    logic       instr_ready;
    logic [7:0] opcode = 8'h00;
    logic [7:0] target = 8'h00;
    logic       cond_taken = 1'b0;
    logic       stall = 1'b0;
    logic [7:0] pc;
    logic       branch_taken;
    logic       halted;
    logic       stack_err;

    int n_vec = 0;
    int n_err = 0;

    leg_pc_seq #(
        .UUID (7),
        .NAME ("tb_inst")
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .opcode       (opcode),
        .target       (target),
        .cond_taken   (cond_taken),
        .stall        (stall),
        .pc           (pc),
        .branch_taken (branch_taken),
        .halted       (halted),
        .stack_err    (stack_err)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [7:0] m_pc   = 8'h00;
    bit         m_boot = 1'b1;
    bit         m_halt = 1'b0;
    bit         m_bt   = 1'b0;
    bit         m_err  = 1'b0;
    logic [7:0] m_stk[$];

    always @(posedge clk or negedge rst) begin
        int o;
        if (!rst) begin
            m_pc = 8'h00; m_boot = 1'b1; m_halt = 1'b0; m_bt = 1'b0; m_err = 1'b0;
            m_stk.delete();
        end else begin
            m_bt = 1'b0;
            o = int'(opcode) % 64;
            if (m_boot) begin
                m_boot = 1'b0;
            end else if (!m_halt && !stall && instr_valid) begin
                if (o == 63) begin
                    m_halt = 1'b1;
                end else if (o >= 32 && o <= 37 && cond_taken) begin
                    m_pc = target; m_bt = 1'b1;
`ifdef LEG_PC_CALL_STACK_EN
                end else if (o == 48) begin
                    if (m_stk.size() < 4) m_stk.push_back(m_pc + 8'd4);
                    else m_err = 1'b1;
                    m_pc = target; m_bt = 1'b1;
                end else if (o == 49) begin
                    if (m_stk.size() > 0) begin
                        m_pc = m_stk.pop_back(); m_bt = 1'b1;
                    end else begin
                        m_pc = m_pc + 8'd4; m_err = 1'b1;
                    end
`endif
                end else begin
                    m_pc = m_pc + 8'd4;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        chk("pc", pc, m_pc);
        chk("branch_taken", {7'd0, branch_taken}, {7'd0, m_bt});
        chk("halted", {7'd0, halted}, {7'd0, m_halt});
        chk("stack_err", {7'd0, stack_err}, {7'd0, m_err});
        chk("instr_ready", {7'd0, instr_ready}, {7'd0, (!m_boot && !m_halt && !stall)});
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic v, input logic [7:0] op, input logic [7:0] tg, input logic ct);
        instr_valid = v; opcode = op; target = tg; cond_taken = ct; stall = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic lit(input string nm, input logic [7:0] exp_pc, input logic exp_bt);
        chk({nm, "_pc"}, pc, exp_pc);
        chk({nm, "_bt"}, {7'd0, branch_taken}, {7'd0, exp_bt});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        lit("reset", 8'h00, 1'b0);
        chk("reset_halted", {7'd0, halted}, 8'h00);
        chk("reset_ready", {7'd0, instr_ready}, 8'h00);
        chk("reset_stack_err", {7'd0, stack_err}, 8'h00);
        rst = 1'b1;

        // Sequential fetch after BOOT
        drive(1, 8'h00, 8'h00, 0); lit("boot", 8'h00, 0);
        drive(1, 8'h00, 8'h00, 0); lit("seq1", 8'h04, 0);
        drive(1, 8'h00, 8'h00, 0); lit("seq2", 8'h08, 0);
        drive(1, 8'h00, 8'h00, 0);
        drive(1, 8'h00, 8'h00, 0); lit("seq4", 8'h10, 0);

        // Conditional branches
        drive(1, 8'h22, 8'h40, 1); lit("cond_taken", 8'h40, 1);
        drive(0, 8'h00, 8'h00, 1); lit("idle", 8'h40, 0);
        drive(1, 8'hE2, 8'h10, 1); lit("cond_immbits", 8'h10, 1);
        drive(1, 8'h22, 8'h40, 0); lit("cond_not", 8'h14, 0);
        drive(1, 8'h05, 8'h99, 1); lit("plain_ct", 8'h18, 0);
        drive(1, 8'h26, 8'h99, 1); lit("above_range", 8'h1C, 0);
        drive(1, 8'h1F, 8'h99, 1); lit("below_range", 8'h20, 0);
        drive(1, 8'hA5, 8'hFC, 1); lit("cond_last", 8'hFC, 1);
        drive(1, 8'h00, 8'h00, 0); lit("wrap", 8'h00, 0);

        // Stall holds everything
        for (int i = 0; i < 3; i++) begin
            instr_valid = 1'b1; opcode = 8'h00; stall = 1'b1;
            #1 chk("stall_ready", {7'd0, instr_ready}, 8'h00);
            @(posedge clk); #1;
            lit("stall", 8'h00, 0);
        end
        drive(1, 8'h00, 8'h00, 0); lit("after_stall", 8'h04, 0);

`ifndef LEG_PC_CALL_STACK_EN
        drive(1, 8'h30, 8'h80, 1); lit("call_plain", 8'h08, 0);
        drive(1, 8'h31, 8'h80, 1); lit("ret_plain", 8'h0C, 0);
        chk("no_stack_err", {7'd0, stack_err}, 8'h00);
`endif

        // Halt
        drive(1, 8'hBF, 8'h00, 0);
        chk("halt_flag", {7'd0, halted}, 8'h01);
        for (int i = 0; i < 3; i++) begin
            drive(1, 8'h22, 8'h40, 1);
            chk("halt_ready", {7'd0, instr_ready}, 8'h00);
        end
`ifndef LEG_PC_CALL_STACK_EN
        lit("halt_frozen", 8'h0C, 0);
`else
        lit("halt_frozen", 8'h04, 0);
`endif
        rst = 1'b0;
        @(posedge clk); #1;
        chk("halt_cleared", {7'd0, halted}, 8'h00);
        lit("halt_reset", 8'h00, 0);
        rst = 1'b1;

`ifdef LEG_PC_CALL_STACK_EN
        drive(1, 8'h00, 8'h00, 0); lit("boot2", 8'h00, 0);
        for (int i = 0; i < 5; i++) begin
            drive(1, 8'h30, 8'h80, 0); lit("call", 8'h80, 1);
            chk("call_err", {7'd0, stack_err}, (i == 4) ? 8'h01 : 8'h00);
        end
        drive(1, 8'h31, 8'h00, 0); lit("ret1", 8'h84, 1);
        drive(1, 8'h31, 8'h00, 0); lit("ret2", 8'h84, 1);
        drive(1, 8'h31, 8'h00, 0); lit("ret3", 8'h84, 1);
        drive(1, 8'h31, 8'h00, 0); lit("ret4", 8'h04, 1);
        drive(1, 8'h31, 8'h00, 0); lit("ret_empty", 8'h08, 0);
        chk("ret_empty_err", {7'd0, stack_err}, 8'h01);
`endif

        // Reset during a taken-branch accept
        drive(1, 8'h00, 8'h00, 0);
        instr_valid = 1'b1; opcode = 8'h22; target = 8'h40; cond_taken = 1'b1;
        #2 rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        lit("rst_mid", 8'h00, 0);
        drive(1, 8'h00, 8'h00, 0); lit("rst_boot", 8'h00, 0);
        drive(1, 8'h00, 8'h00, 0); lit("rst_fetch", 8'h04, 0);

        drive(0, 8'h00, 8'h00, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/leg_pc_seq.md
LEG_PC_SEQ -- requirements
Module: leg_pc_seq

Interface
REQ-001 Parameter: UUID, default 0, instance identifier, no functional effect.
REQ-002 Parameter: NAME, default "", instance label, no functional effect.
REQ-003 clk  input  1  sole clock; all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 instr_valid  input  1  fetched instruction bytes present this cycle.
REQ-006 instr_ready  output  1  sequencer accepts instruction this cycle.
REQ-007 opcode  input  8  instruction byte 0.
REQ-008 target  input  8  instruction byte 3; jump/call destination.
REQ-009 cond_taken  input  1  condition-unit result for the presented opcode, combinational, same cycle.
REQ-010 stall  input  1  downstream busy; blocks acceptance.
REQ-011 pc  output  8  current instruction address, registered.
REQ-012 branch_taken  output  1  one-cycle pulse after a taken branch, call or return.
REQ-013 halted  output  1  high while in HALT.
REQ-014 stack_err  output  1  sticky call-stack overflow/underflow flag.

Function
REQ-015 FSM states: BOOT, RUN, HALT; BOOT -> RUN unconditionally after one cycle.
REQ-016 instr_ready = (state==RUN) && !stall; accept = instr_valid && instr_ready.
REQ-017 No accept -> pc, state and stack unchanged; branch_taken low next cycle.
REQ-018 Conditional op: opcode[5:0] in 0x20..0x25, opcode[7:6] ignored (immediate-mode bits).
REQ-019 Accepted conditional op with cond_taken=1 -> pc <= target next cycle, branch_taken=1 for that cycle.
REQ-020 Accepted conditional op with cond_taken=0 -> pc <= pc+4.
REQ-021 Accepted non-conditional, non-control op -> pc <= pc+4; cond_taken ignored.
REQ-022 pc arithmetic is 8-bit modulo 256; 0xFC+4 = 0x00, no flag.
REQ-023 Accepted opcode[5:0]==HALT_OP (0x3F) -> state HALT, pc unchanged; halted=1 next cycle.
REQ-024 HALT exits only via reset; instr_ready=0 throughout.
REQ-025 Latency: pc and branch_taken reflect an accepted instruction exactly one cycle after accept.
REQ-026 stall asserted with instr_valid -> instruction held upstream; no side effects.

Reset
REQ-027 rst low -> immediately: pc=0x00, state=BOOT, branch_taken=0, halted=0, stack_err=0, stack empty.
REQ-028 Reset mid-operation discards the in-flight accept; first fetch after release is from 0x00.

Configuration
REQ-029 Macro LEG_PC_CALL_STACK_EN compiles in a 4-entry return stack.
REQ-030 With macro: accepted CALL_OP (opcode[5:0]==0x30) pushes pc+4, pc <= target, branch_taken pulse.
REQ-031 With macro: accepted RET_OP (0x31) pops -> pc <= popped value, branch_taken pulse.
REQ-032 With macro: CALL when full -> push dropped, jump still taken, stack_err set.
REQ-033 With macro: RET when empty -> pc <= pc+4, no pulse, stack_err set.
REQ-034 Without macro: 0x30/0x31 are ordinary ops (pc+4), stack_err tied 0, port retained.

Structure
REQ-035 Shared package leg_pkg holds COND_FIRST=0x20, COND_LAST=0x25, CALL_OP, RET_OP, HALT_OP, PC_STEP=4 and the FSM state enum.
REQ-036 One sub-module leg_ret_stack (push/pop/full/empty, depth 4), instantiated only under the macro.

Verification
REQ-037 Reset release, instr_valid=1, opcode=0x00 every cycle -> pc 0x00, 0x04, 0x08 after BOOT cycle.
REQ-038 pc=0x10, opcode=0x22, cond_taken=1, target=0x40 -> pc=0x40, branch_taken=1 one cycle; cond_taken=0 -> pc=0x14.
REQ-039 pc=0xFC, opcode=0x00 accepted -> pc=0x00; stall=1 for 3 cycles -> instr_ready=0, pc held.
REQ-040 opcode=0x3F accepted -> halted=1, pc frozen, instr_ready=0 until rst low.
REQ-041 Macro on: 5 CALLs from 0x00 with target=0x80 -> stack_err=1 after fifth; 4 RETs return 0x84,0x84,0x84,0x04; fifth RET -> pc+4.
REQ-042 rst low during taken-branch accept -> pc=0x00, branch_taken=0 on release.
